// File: rtl/instr_fetch.sv
// instr_fetch: program-counter sequencer for a small processor.
// Three-state control (IDLE / RUN / DONE) steps ProgCtr through the
// instruction ROM, taking absolute or PC-relative branches and stopping on halt.
// Optional macro FETCH_INST_COUNT_EN adds a saturating 16-bit InstCount output
// counting cycles spent in RUN.
module instr_fetch (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       branch_en,
  input  logic       taken,
  input  logic       branch_rel,
  input  logic [9:0] target,
  input  logic       halt,
  output logic [9:0] ProgCtr,
  output logic       running,
  output logic       Done
`ifdef FETCH_INST_COUNT_EN
  ,
  output logic [15:0] InstCount
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Relative branch: a 10-bit two's-complement offset added modulo 1024.
  function automatic logic [9:0] rel_add(input logic [9:0] pc, input logic signed [9:0] off);
    logic [9:0] sum;
    sum = pc + off;
    return sum;
  endfunction

  // Sequential increment; 1023 wraps naturally to 0.
  function automatic logic [9:0] inc_pc(input logic [9:0] pc);
    return pc + 10'd1;
  endfunction

  // Control state machine with registered ProgCtr, running and Done.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      ProgCtr <= 10'd0;
      running <= 1'b0;
      Done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ProgCtr <= 10'd0;
          if (Start) begin
            state   <= RUN;
            running <= 1'b1;
            Done    <= 1'b0;
          end
        end
        RUN: begin
          // halt wins over any branch in the same instruction
          if (halt) begin
            state   <= DONE;
            running <= 1'b0;
            Done    <= 1'b1;
          end else if (branch_en && taken) begin
            ProgCtr <= branch_rel ? rel_add(ProgCtr, target) : target;
          end else begin
            ProgCtr <= inc_pc(ProgCtr);
          end
        end
        DONE: begin
          if (Start) begin
            state   <= RUN;
            ProgCtr <= 10'd0;
            running <= 1'b1;
            Done    <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          ProgCtr <= 10'd0;
          running <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_INST_COUNT_EN
  // Saturating increment so a long program pins at 65535 instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // Count edges spent in RUN (halt cycle included); clear on (re)entry to RUN.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      InstCount <= 16'd0;
    end else if (state == RUN) begin
      InstCount <= sat_inc(InstCount);
    end else if (Start) begin
      InstCount <= 16'd0;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal
// expectations plus randomized stimulus compared every cycle against a
// behavioural model. Define FETCH_INST_COUNT_EN to also cover InstCount.
module tb_instr_fetch;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       branch_en = 1'b0;
  logic       taken = 1'b0;
  logic       branch_rel = 1'b0;
  logic [9:0] target = 10'd0;
  logic       halt = 1'b0;
  logic [9:0] ProgCtr;
  logic       running;
  logic       Done;
`ifdef FETCH_INST_COUNT_EN
  logic [15:0] InstCount;
`endif

  instr_fetch dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .branch_en(branch_en),
    .taken(taken),
    .branch_rel(branch_rel),
    .target(target),
    .halt(halt),
    .ProgCtr(ProgCtr),
    .running(running),
    .Done(Done)
`ifdef FETCH_INST_COUNT_EN
    ,
    .InstCount(InstCount)
`endif
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: mode 0 = idle, 1 = executing, 2 = finished.
  int  m_mode = 0;
  int  m_pc = 0;
  int  m_cnt = 0;
  bit  m_valid = 1'b0;

  always @(posedge Clk) begin
    int off;
    if (Reset) begin
      m_mode  = 0;
      m_pc    = 0;
      m_cnt   = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_mode == 1) begin
        m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        if (halt) begin
          m_mode = 2;
        end else if (branch_en && taken) begin
          if (branch_rel) begin
            off  = (int'(target) >= 512) ? int'(target) - 1024 : int'(target);
            m_pc = (m_pc + off + 1024) % 1024;
          end else begin
            m_pc = int'(target);
          end
        end else begin
          m_pc = (m_pc + 1) % 1024;
        end
      end else if (Start) begin
        m_mode = 1;
        m_pc   = 0;
        m_cnt  = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (m_valid) begin
      checks++;
      if (int'(ProgCtr) != m_pc) begin
        errors++;
        $display("FAIL model_pc t=%0t actual=%0d required=%0d", $time, ProgCtr, m_pc);
      end
      checks++;
      if (running !== (m_mode == 1)) begin
        errors++;
        $display("FAIL model_running t=%0t actual=%0b required=%0b", $time, running, (m_mode == 1));
      end
      checks++;
      if (Done !== (m_mode == 2)) begin
        errors++;
        $display("FAIL model_done t=%0t actual=%0b required=%0b", $time, Done, (m_mode == 2));
      end
`ifdef FETCH_INST_COUNT_EN
      checks++;
      if (int'(InstCount) != m_cnt) begin
        errors++;
        $display("FAIL model_count t=%0t actual=%0d required=%0d", $time, InstCount, m_cnt);
      end
`endif
    end
  end

  task automatic expect_eq(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, return just after the rising edge.
  task automatic apply(input logic rst, input logic st, input logic be, input logic tk,
                       input logic rel, input logic [9:0] tg, input logic h);
    @(negedge Clk);
    Reset = rst; Start = st; branch_en = be; taken = tk;
    branch_rel = rel; target = tg; halt = h;
    @(posedge Clk);
    #1;
  endtask

  task automatic plain();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
  endtask

  task automatic jump_abs(input logic [9:0] tg);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, tg, 1'b0);
  endtask

  initial begin
    // Reset state
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
    expect_eq("reset_pc", int'(ProgCtr), 0);
    expect_eq("reset_running", int'(running), 0);
    expect_eq("reset_done", int'(Done), 0);

    // Idle ignores branch inputs
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd300, 1'b1);
    expect_eq("idle_hold_pc", int'(ProgCtr), 0);
    expect_eq("idle_running", int'(running), 0);

    // Start then five sequential steps
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
    expect_eq("start_pc", int'(ProgCtr), 0);
    expect_eq("start_running", int'(running), 1);
    for (int i = 1; i <= 5; i++) begin
      plain();
      expect_eq($sformatf("seq_pc_%0d", i), int'(ProgCtr), i);
      expect_eq($sformatf("seq_running_%0d", i), int'(running), 1);
    end

    // Relative branch back by 3, and not-taken branch
    jump_abs(10'd10);
    expect_eq("abs_to_10", int'(ProgCtr), 10);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'h3FD, 1'b0);
    expect_eq("rel_minus3", int'(ProgCtr), 7);
    jump_abs(10'd10);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h3FD, 1'b0);
    expect_eq("rel_not_taken", int'(ProgCtr), 11);

    // Relative forward with wrap: 1020 + 10 = 1030 mod 1024 = 6
    jump_abs(10'd1020);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd10, 1'b0);
    expect_eq("rel_wrap", int'(ProgCtr), 6);

    // Wrap at 1023, absolute to 512
    jump_abs(10'd1023);
    expect_eq("abs_to_1023", int'(ProgCtr), 1023);
    plain();
    expect_eq("wrap_to_0", int'(ProgCtr), 0);
    jump_abs(10'd512);
    expect_eq("abs_to_512", int'(ProgCtr), 512);

    // Start during RUN is ignored
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
    expect_eq("start_in_run", int'(ProgCtr), 513);

    // halt beats branch
    jump_abs(10'd20);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd99, 1'b1);
    expect_eq("halt_done", int'(Done), 1);
    expect_eq("halt_pc", int'(ProgCtr), 20);
    expect_eq("halt_running", int'(running), 0);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd99, 1'b0);
    expect_eq("done_hold_pc", int'(ProgCtr), 20);
    expect_eq("done_hold_done", int'(Done), 1);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
    expect_eq("restart_pc", int'(ProgCtr), 0);
    expect_eq("restart_running", int'(running), 1);
    expect_eq("restart_done", int'(Done), 0);

    // Reset mid-RUN overrides Start and halt
    jump_abs(10'd37);
    expect_eq("abs_to_37", int'(ProgCtr), 37);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd5, 1'b1);
    expect_eq("midrun_reset_pc", int'(ProgCtr), 0);
    expect_eq("midrun_reset_done", int'(Done), 0);
    expect_eq("midrun_reset_running", int'(running), 0);

    // Eight RUN cycles then halt
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
    for (int i = 0; i < 8; i++) plain();
    expect_eq("count_run_pc", int'(ProgCtr), 8);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1);
    expect_eq("count_halt_done", int'(Done), 1);
`ifdef FETCH_INST_COUNT_EN
    expect_eq("inst_count_9", int'(InstCount), 9);
    plain();
    expect_eq("inst_count_hold", int'(InstCount), 9);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
    expect_eq("inst_count_clear", int'(InstCount), 0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      Reset      = ($urandom % 97) == 0;
      Start      = ($urandom % 10) == 0;
      halt       = ($urandom % 25) == 0;
      branch_en  = ($urandom % 3) == 0;
      taken      = $urandom % 2;
      branch_rel = $urandom % 2;
      target     = 10'($urandom % 1024);
    end
    @(negedge Clk);
    Reset = 1'b0; Start = 1'b0; halt = 1'b0; branch_en = 1'b0;
    @(negedge Clk);
    @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
